// File: rtl/aesl_deadlock_stall_detector.sv
// aesl_deadlock_stall_detector
// Per-kernel deadlock detector. It flags the kernel as deadlocked once it has
// been blocked, with no change on the instance idle vector, for THRESHOLD
// consecutive cycles. The block flag is sticky until clear or reset.
// Optional feature macro: AESL_DEADLOCK_CAUSE_CAPTURE_EN adds block_first_idx,
// which holds the lowest blocked AXIS index at the moment of detection.
// The FSM state is visible on fsm_state (RUN=0, SUSPECT=1, BLOCKED=2).
module aesl_deadlock_stall_detector #(
   parameter int N_AXIS    = 1,
   parameter int N_INST    = 2,
   parameter int N_IBLK    = 1,
   parameter int THRESHOLD = 16,
   parameter int CNT_W     = 16,
   localparam int IDX_W    = (N_AXIS > 1) ? $clog2(N_AXIS) : 1
) (
   input  logic              clock,
   input  logic              reset_n,
   input  logic [N_AXIS-1:0] axis_block_sigs,
   input  logic [N_INST-1:0] inst_idle_sigs,
   input  logic [N_IBLK-1:0] inst_block_sigs,
   input  logic              clear,
   output logic              block,
   output logic [CNT_W-1:0]  stall_count,
   output logic [CNT_W-1:0]  block_cycles,
`ifdef AESL_DEADLOCK_CAUSE_CAPTURE_EN
   output logic [IDX_W-1:0]  block_first_idx,
`endif
   output logic [1:0]        fsm_state
);

   typedef enum logic [1:0] {
      ST_RUN     = 2'd0,
      ST_SUSPECT = 2'd1,
      ST_BLOCKED = 2'd2
   } state_e;

   localparam logic [CNT_W-1:0] THR_C   = CNT_W'(THRESHOLD);
   localparam logic [CNT_W-1:0] SAT_C   = {CNT_W{1'b1}};
   localparam logic [CNT_W-1:0] ONE_C   = CNT_W'(1);

   state_e              state_q;
   logic [N_INST-1:0]   idle_q;
   logic [CNT_W-1:0]    stall_cnt_q;
   logic [CNT_W-1:0]    block_cyc_q;
   logic                block_q;

   logic                any_blk;
   logic                progress;
   logic                stall;
   logic [CNT_W-1:0]    cnt_inc_d;
   logic                enter_blocked_d;

   // Stall qualification: blocked somewhere and no idle-state movement.
   always_comb begin
      any_blk         = (|axis_block_sigs) | (|inst_block_sigs);
      progress        = (inst_idle_sigs != idle_q);
      stall           = any_blk & ~progress;
      cnt_inc_d       = stall_cnt_q + ONE_C;
      enter_blocked_d = 1'b0;
      if (!clear && stall) begin
         if (state_q == ST_RUN)
            enter_blocked_d = (THRESHOLD == 1);
         else if (state_q == ST_SUSPECT)
            enter_blocked_d = (cnt_inc_d == THR_C);
      end
   end

   // Detector FSM with registered counters and sticky block flag; clear wins.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q     <= ST_RUN;
         idle_q      <= '1;
         stall_cnt_q <= '0;
         block_cyc_q <= '0;
         block_q     <= 1'b0;
      end else begin
         idle_q <= inst_idle_sigs;
         if (clear) begin
            state_q     <= ST_RUN;
            stall_cnt_q <= '0;
            block_cyc_q <= '0;
            block_q     <= 1'b0;
         end else begin
            case (state_q)
               ST_RUN: begin
                  if (stall) begin
                     stall_cnt_q <= ONE_C;
                     if (enter_blocked_d) begin
                        state_q <= ST_BLOCKED;
                        block_q <= 1'b1;
                     end else begin
                        state_q <= ST_SUSPECT;
                     end
                  end
               end
               ST_SUSPECT: begin
                  if (stall) begin
                     stall_cnt_q <= cnt_inc_d;
                     if (enter_blocked_d) begin
                        state_q <= ST_BLOCKED;
                        block_q <= 1'b1;
                     end
                  end else begin
                     state_q     <= ST_RUN;
                     stall_cnt_q <= '0;
                  end
               end
               ST_BLOCKED: begin
                  // Only clear or reset leaves; stall_count is frozen here.
                  if (block_cyc_q != SAT_C)
                     block_cyc_q <= block_cyc_q + ONE_C;
               end
               default: begin
                  state_q     <= ST_RUN;
                  stall_cnt_q <= '0;
                  block_cyc_q <= '0;
                  block_q     <= 1'b0;
               end
            endcase
         end
      end
   end

`ifdef AESL_DEADLOCK_CAUSE_CAPTURE_EN
   logic [IDX_W-1:0] first_idx_d;
   logic [IDX_W-1:0] first_idx_q;

   // Priority encoder: lowest blocked AXIS index wins, 0 when none is set.
   always_comb begin
      first_idx_d = '0;
      for (int i = N_AXIS - 1; i >= 0; i--) begin
         if (axis_block_sigs[i])
            first_idx_d = IDX_W'(i);
      end
   end

   // Capture the cause on the edge that enters BLOCKED.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n)
         first_idx_q <= '0;
      else if (clear)
         first_idx_q <= '0;
      else if (enter_blocked_d)
         first_idx_q <= first_idx_d;
   end

   assign block_first_idx = first_idx_q;
`endif

   assign block        = block_q;
   assign stall_count  = stall_cnt_q;
   assign block_cycles = block_cyc_q;
   assign fsm_state    = state_q;

endmodule

// File: doc/aesl_deadlock_stall_detector.md
# aesl_deadlock_stall_detector

Per-kernel deadlock detector that sits directly downstream of the kernel monitor top's signal collection. It consumes the per-kernel AXI-stream block vector, instance idle vector and instance block vector, and decides when the kernel is genuinely deadlocked: blocked with no idle-state activity for a programmable number of consecutive cycles. It then drives a sticky `block` flag to the simulation deadlock trigger, plus diagnostic counters.

## Interface
- `N_AXIS`, 1: width of `axis_block_sigs`.
- `N_INST`, 2: width of `inst_idle_sigs`.
- `N_IBLK`, 1: width of `inst_block_sigs`.
- `THRESHOLD`, 16: consecutive stalled cycles before `block` asserts. Legal range is 1 to 2^`CNT_W`-1.
- `CNT_W`, 16: width of the stall and block counters.

Ports:
- `clock`  in  1  single clock for all state.
- `reset_n`  in  1  asynchronous, active-low reset.
- `axis_block_sigs`  in  `N_AXIS`  1 = that AXI-stream port is blocked (TDATA_blk_n inverted upstream).
- `inst_idle_sigs`  in  `N_INST`  ap_idle of each tracked instance.
- `inst_block_sigs`  in  `N_IBLK`  1 = that instance is blocked.
- `clear`  in  1  synchronous one-cycle pulse; rearms the detector.
- `block`  out  1  kernel deadlocked; sticky.
- `stall_count`  out  `CNT_W`  current consecutive-stall count.
- `block_cycles`  out  `CNT_W`  cycles spent in BLOCKED; saturating.
- `block_first_idx`  out  `$clog2(N_AXIS)` (minimum 1)  lowest blocked AXIS index at the moment of detection. Present only with the macro.

## Operation
- `any_blk` = OR of `axis_block_sigs` OR OR of `inst_block_sigs`.
- `idle_q` is `inst_idle_sigs` registered; reset value all-ones.
- `progress` = (`inst_idle_sigs` != `idle_q`).
- `stall` = `any_blk` AND NOT `progress`.
- FSM states:
  - RUN: `stall_count`=0. If `stall`, go to SUSPECT and set count to 1. If `THRESHOLD`==1, go directly to BLOCKED.
  - SUSPECT: if `stall`, count+1. When the incremented count equals `THRESHOLD`, go to BLOCKED. If NOT `stall`, go to RUN and set count to 0.
  - BLOCKED: `block`=1. `stall_count` holds its value. `block_cycles` increments each cycle, saturating at 2^`CNT_W`-1. Input activity does NOT leave BLOCKED; only `clear` or reset does.
- `clear` has priority over every transition in every state. The next state is RUN, with `stall_count`=0, `block_cycles`=0 and `block_first_idx`=0.
- A stall that ends exactly on the cycle where the count would reach `THRESHOLD` does not assert `block`.
- `block_first_idx` is captured on the RUN/SUSPECT→BLOCKED edge. It holds 0 if no AXIS bit is set, i.e. only instance blocks caused the detection.

## Timing
- Reset values: FSM=RUN, `block`=0, `stall_count`=0, `block_cycles`=0, `block_first_idx`=0, `idle_q`=all-ones.
- All outputs are registered, with no combinational input-to-output path.
- With `stall` sampled true at clock edges 1..`THRESHOLD`, `block` is 1 after edge `THRESHOLD`.
- `block_cycles` reads 1 one edge after `block` rises.
- Asynchronous reset mid-SUSPECT or mid-BLOCKED returns to the reset values immediately. The first count is possible at the first edge after `reset_n` deasserts.
- If `clear` and `stall` are asserted together, the block goes to RUN; counting restarts from the next edge.

## Configuration
- `AESL_DEADLOCK_CAUSE_CAPTURE_EN`:
  - Defined: the `block_first_idx` port and its capture register (priority encoder, lowest index wins) are present.
  - Undefined: the port and its logic are absent; all other behaviour is identical.

## Test plan
- Reset → all outputs 0. Hold `axis_block_sigs`=1 with idle constant, `THRESHOLD`=16 → `block`=0 after edge 15 and `block`=1 after edge 16.
- Stall for 10 cycles, toggle `inst_idle_sigs[1]` for one cycle, then stall again → `stall_count` returns to 0 and `block` rises 16 edges after the stall resumes.
- In BLOCKED, deassert all block inputs for 50 cycles → `block` stays 1 and `block_cycles`=50. Pulse `clear` → all outputs 0 on the next edge.
- `CNT_W`=4, `THRESHOLD`=3, hold blocked for 40 cycles → `block_cycles` saturates at 15.
- With the macro defined, `N_AXIS`=4, `axis_block_sigs`=4'b1100 held → `block_first_idx`=2. With only `inst_block_sigs` set → `block_first_idx`=0.
- Deassert `reset_n` asynchronously mid-SUSPECT (count 7) → `stall_count`=0 and FSM=RUN without waiting for a clock edge.
